// File: rtl/pack_sk_stream.sv
// Streaming Dilithium secret-key packer: emits rho|key|tr followed by eta-packed s1/s2
// and 13-bit t0 coefficients as OUT_W-bit little-endian words with a ready/valid handshake.
module pack_sk_stream #(
  parameter int K     = 6,
  parameter int L     = 5,
  parameter int ETA   = 4,
  parameter int OUT_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [255:0]       rho_in,
  input  logic [255:0]       key_in,
  input  logic [511:0]       tr_in,
  input  logic signed [31:0] coef_in,
  input  logic               coef_valid,
  output logic               coef_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               range_err
);

  localparam int EB    = (ETA == 2) ? 3 : 4;
  localparam int NTOT  = (L + 2*K) * 256;
  localparam int NS2   = (L + K) * 256;
  localparam int SEEDW = 1024 / OUT_W;
  localparam int ACC_W = OUT_W + 13;
  localparam int NW    = $clog2(NTOT + 1);
  localparam int FW    = $clog2(ACC_W + 1);
  localparam int SW    = $clog2(SEEDW + 1);

  localparam logic [NW-1:0]     NTOT_N    = NW'(NTOT);
  localparam logic [NW-1:0]     NS2_N     = NW'(NS2);
  localparam logic [FW-1:0]     OUT_WF    = FW'(OUT_W);
  localparam logic [FW-1:0]     EB_WF     = FW'(EB);
  localparam logic [FW-1:0]     T0_WF     = FW'(13);
  localparam logic [SW-1:0]     SEED_LAST = SW'(SEEDW - 1);
  localparam logic [12:0]       EB_MASK   = 13'((1 << EB) - 1);
  localparam logic signed [31:0] ETA_S    = 32'(ETA);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEED = 2'd1;
  localparam logic [1:0] COEF = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [NW-1:0]    n_q, n_d;
  logic [FW-1:0]    f_q, f_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1023:0]    seed_q, seed_d;

  logic             is_t0;
  logic [12:0]      p_val;
  logic [FW-1:0]    p_w;
  logic             c_ok;

  // Only the low 13 bits of c matter: the packed field is a modular difference.
  function automatic logic [12:0] map_coef(input logic [12:0] c_lo, input logic t0);
    logic [12:0] d;
    d = t0 ? (13'd4096 - c_lo) : (13'(ETA) - c_lo);
    return t0 ? d : (d & EB_MASK);
  endfunction

  function automatic logic coef_in_range(input logic signed [31:0] c, input logic t0);
    if (t0) return (c >= -32'sd4095) && (c <= 32'sd4096);
    return (c >= -ETA_S) && (c <= ETA_S);
  endfunction

  assign is_t0     = (n_q >= NS2_N);
  assign p_val     = map_coef(coef_in[12:0], is_t0);
  assign p_w       = is_t0 ? T0_WF : EB_WF;
  assign c_ok      = coef_in_range(coef_in, is_t0);
  assign range_err = err_q;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    f_d        = f_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    seed_d     = seed_q;
    coef_ready = 1'b0;
    out_valid  = 1'b0;
    out_data   = '0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEED;
          seed_d  = {tr_in, key_in, rho_in};
          cnt_d   = '0;
          n_d     = '0;
          f_d     = '0;
          acc_d   = '0;
          err_d   = 1'b0;
        end
      end
      SEED: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = seed_q[OUT_W-1:0];
        if (out_ready) begin
          seed_d = seed_q >> OUT_W;
          if (cnt_q == SEED_LAST) begin
            state_d = COEF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + SW'(1);
          end
        end
      end
      COEF: begin
        busy       = 1'b1;
        out_valid  = (f_q >= OUT_WF);
        out_data   = acc_q[OUT_W-1:0];
        coef_ready = (f_q < OUT_WF) && (n_q != NTOT_N);
        // coef_ready and out_valid never overlap, so only one branch can fire.
        if (coef_ready && coef_valid) begin
          acc_d = acc_q | (ACC_W'(p_val) << f_q);
          f_d   = f_q + p_w;
          n_d   = n_q + NW'(1);
          if (!c_ok) err_d = 1'b1;
        end else if (out_valid && out_ready) begin
          acc_d = acc_q >> OUT_W;
          f_d   = f_q - OUT_WF;
          if ((n_q == NTOT_N) && (f_q == OUT_WF)) state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      f_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      f_q     <= f_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Seed shift register is pure data; it is loaded on every accepted start.
  always_ff @(posedge clk) begin
    seed_q <= seed_d;
  end

endmodule
